// File: rtl/pattern_pixel_gen.sv
// Procedural raster pixel source: walks an FB_W x FB_H cell grid and emits one
// (hpos, vpos, RGB) beat per valid/ready handshake, colour from a latched pattern mode.
module pattern_pixel_gen #(
    parameter int FB_W         = 80,
    parameter int FB_H         = 60,
    parameter int CELL_SHIFT   = 4,
    parameter int CHK_SHIFT    = 0,
    parameter int BAR_SHIFT    = 3,
    parameter int X_WIRE_WIDTH = 11,
    parameter int Y_WIRE_WIDTH = 10,
    parameter int XC_W         = $clog2(FB_W),
    parameter int YC_W         = $clog2(FB_H)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    cont,
    input  logic [1:0]              mode,
    input  logic [2:0]              color,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [X_WIRE_WIDTH-1:0] hpos,
    output logic [Y_WIRE_WIDTH-1:0] vpos,
    output logic [2:0]              RGB,
    output logic                    busy,
    output logic                    frame_done
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                    state_q, state_d;
    logic [XC_W-1:0]           x_q, x_d;
    logic [YC_W-1:0]           y_q, y_d;
    logic [1:0]                mode_q, mode_d;
    logic [2:0]                color_q, color_d;
    logic                      cont_q, cont_d;
    logic [X_WIRE_WIDTH-1:0]   hpos_q, hpos_d;
    logic [Y_WIRE_WIDTH-1:0]   vpos_q, vpos_d;
    logic [2:0]                rgb_q, rgb_d;
    logic                      done_q, done_d;

    logic                      last_beat;
    logic                      load_frame;
    logic                      step_beat;
    logic                      present;

    function automatic logic [2:0] pattern(input logic [XC_W-1:0] x,
                                           input logic [YC_W-1:0] y,
                                           input logic [1:0]      m,
                                           input logic [2:0]      c);
        logic [2:0] r;
        r = c;
        case (m)
            2'd1: begin
                if (1'(32'(x) >> CHK_SHIFT) ^ 1'(32'(y) >> CHK_SHIFT))
                    r = ~c;
            end
            2'd2:    r = 3'(32'(x) >> BAR_SHIFT) ^ c;
            2'd3:    r = 3'(32'(y) >> BAR_SHIFT) ^ c;
            default: r = c;
        endcase
        return r;
    endfunction

    assign last_beat = (x_q == XC_W'(FB_W - 1)) && (y_q == YC_W'(FB_H - 1));

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        mode_d     = mode_q;
        color_d    = color_q;
        cont_d     = cont_q;
        hpos_d     = hpos_q;
        vpos_d     = vpos_q;
        rgb_d      = rgb_q;
        done_d     = 1'b0;
        load_frame = 1'b0;
        step_beat  = 1'b0;
        present    = 1'b0;

        // stop outranks both start and a same-cycle handshake
        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    state_d    = S_RUN;
                    load_frame = 1'b1;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (out_ready) begin
                    if (last_beat) begin
                        done_d = 1'b1;
                        if (cont_q) load_frame = 1'b1;
                        else        state_d    = S_IDLE;
                    end else begin
                        step_beat = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load_frame) begin
            mode_d  = mode;
            color_d = color;
            cont_d  = cont;
            x_d     = '0;
            y_d     = '0;
            present = 1'b1;
        end

        if (step_beat) begin
            if (x_q == XC_W'(FB_W - 1)) begin
                x_d = '0;
                y_d = y_q + YC_W'(1);
            end else begin
                x_d = x_q + XC_W'(1);
            end
            present = 1'b1;
        end

        // held otherwise, so a stalled beat stays stable
        if (present) begin
            hpos_d = X_WIRE_WIDTH'(x_d) << CELL_SHIFT;
            vpos_d = Y_WIRE_WIDTH'(y_d) << CELL_SHIFT;
            rgb_d  = pattern(x_d, y_d, mode_d, color_d);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            mode_q  <= '0;
            color_q <= '0;
            cont_q  <= 1'b0;
            hpos_q  <= '0;
            vpos_q  <= '0;
            rgb_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            mode_q  <= mode_d;
            color_q <= color_d;
            cont_q  <= cont_d;
            hpos_q  <= hpos_d;
            vpos_q  <= vpos_d;
            rgb_q   <= rgb_d;
            done_q  <= done_d;
        end
    end

    assign out_valid  = (state_q == S_RUN);
    assign busy       = (state_q == S_RUN);
    assign hpos       = hpos_q;
    assign vpos       = vpos_q;
    assign RGB        = rgb_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_pattern_pixel_gen.sv
// Bench for pattern_pixel_gen: a beat-index reference model checked every cycle,
// plus literal beat sequences for each directed scenario.
module tb_pattern_pixel_gen;

    localparam int FB_W = 4, FB_H = 2, CS = 2, CHK = 0, BAR = 1;
    localparam int XW = 11, YW = 10, NBEATS = FB_W * FB_H;

    logic          clk = 1'b0;
    logic          rst = 1'b1, start = 1'b0, stop = 1'b0, cont = 1'b0, out_ready = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [2:0]    color = 3'd0;
    logic          out_valid, busy, frame_done;
    logic [XW-1:0] hpos;
    logic [YW-1:0] vpos;
    logic [2:0]    RGB;

    pattern_pixel_gen #(
        .FB_W(FB_W), .FB_H(FB_H), .CELL_SHIFT(CS), .CHK_SHIFT(CHK), .BAR_SHIFT(BAR),
        .X_WIRE_WIDTH(XW), .Y_WIRE_WIDTH(YW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .cont(cont),
        .mode(mode), .color(color), .out_ready(out_ready), .out_valid(out_valid),
        .hpos(hpos), .vpos(vpos), .RGB(RGB), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] pat(input int x, input int y, input logic [1:0] m, input logic [2:0] c);
        case (m)
            2'd0:    return c;
            2'd1:    return (((x >> CHK) ^ (y >> CHK)) & 1) != 0 ? ~c : c;
            2'd2:    return 3'((x >> BAR) & 7) ^ c;
            default: return 3'((y >> BAR) & 7) ^ c;
        endcase
    endfunction

    // Reference model: beat index k within a frame, positions derived arithmetically.
    bit         m_run = 0, m_done = 0, m_known = 0, m_cont = 0;
    int         m_k = 0, m_h = 0, m_v = 0;
    logic [1:0] m_mode = 0;
    logic [2:0] m_color = 0, m_rgb = 0;

    task automatic m_present();
        m_h   = (m_k % FB_W) << CS;
        m_v   = (m_k / FB_W) << CS;
        m_rgb = pat(m_k % FB_W, m_k / FB_W, m_mode, m_color);
    endtask

    task automatic m_new_frame();
        m_mode = mode; m_color = color; m_cont = cont; m_k = 0;
        m_present();
    endtask

    always @(posedge clk) begin
        m_done = 0;
        if (rst) begin
            m_run = 0; m_k = 0; m_mode = 0; m_color = 0; m_cont = 0;
            m_h = 0; m_v = 0; m_rgb = 0; m_known = 1;
        end else if (!m_run) begin
            if (start && !stop) begin
                m_run = 1; m_known = 1;
                m_new_frame();
            end
        end else if (stop) begin
            m_run = 0; m_known = 0;
        end else if (out_ready) begin
            if (m_k == NBEATS - 1) begin
                m_done = 1;
                if (m_cont) m_new_frame();
                else        m_run = 0;
            end else begin
                m_k++;
                m_present();
            end
        end
    end

    int cyc = 0, done_cnt = 0;
    int cap_h[$], cap_v[$], cap_r[$], cap_t[$], done_t[$];

    always @(negedge clk) begin
        cyc++;
        chk("out_valid", 32'(out_valid), 32'(m_run));
        chk("busy", 32'(busy), 32'(m_run));
        chk("frame_done", 32'(frame_done), 32'(m_done));
        if (m_known) begin
            chk("hpos", 32'(hpos), 32'(m_h));
            chk("vpos", 32'(vpos), 32'(m_v));
            chk("RGB", 32'(RGB), 32'(m_rgb));
        end
        if (out_valid && out_ready && !stop && !rst) begin
            cap_h.push_back(int'(hpos));
            cap_v.push_back(int'(vpos));
            cap_r.push_back(int'(RGB));
            cap_t.push_back(cyc);
        end
        if (frame_done) begin
            done_cnt++;
            done_t.push_back(cyc);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic clear_caps();
        cap_h.delete(); cap_v.delete(); cap_r.delete(); cap_t.delete(); done_t.delete();
        done_cnt = 0;
    endtask

    int s1_h[8] = '{0, 4, 8, 12, 0, 4, 8, 12};
    int s1_v[8] = '{0, 0, 0, 0, 4, 4, 4, 4};
    int s2_r[8] = '{1, 6, 1, 6, 6, 1, 6, 1};
    int s3_r[16] = '{0, 0, 1, 1, 0, 0, 1, 1, 7, 7, 6, 6, 7, 7, 6, 6};

    initial begin
        step(3);
        chk("reset out_valid", 32'(out_valid), 0);
        chk("reset hpos", 32'(hpos), 0);
        chk("reset RGB", 32'(RGB), 0);
        rst = 1'b0;
        step(1);

        // Solid single frame
        clear_caps();
        mode = 2'd0; color = 3'b100; cont = 1'b0; out_ready = 1'b1;
        pulse_start();
        step(12);
        chk("s1 beat count", 32'(cap_h.size()), 8);
        for (int i = 0; i < 8 && i < cap_h.size(); i++) begin
            chk("s1 hpos", 32'(cap_h[i]), 32'(s1_h[i]));
            chk("s1 vpos", 32'(cap_v[i]), 32'(s1_v[i]));
            chk("s1 RGB", 32'(cap_r[i]), 4);
        end
        for (int i = 1; i < cap_t.size(); i++)
            chk("s1 back-to-back", 32'(cap_t[i] - cap_t[i-1]), 1);
        chk("s1 done pulses", 32'(done_cnt), 1);
        chk("s1 idle valid", 32'(out_valid), 0);
        chk("s1 idle busy", 32'(busy), 0);

        // Checker with alternating back-pressure
        clear_caps();
        mode = 2'd1; color = 3'b001; cont = 1'b0; out_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 24; i++) begin
            out_ready = ~out_ready;
            step(1);
        end
        out_ready = 1'b1;
        step(2);
        chk("s2 beat count", 32'(cap_r.size()), 8);
        for (int i = 0; i < 8 && i < cap_r.size(); i++)
            chk("s2 RGB", 32'(cap_r[i]), 32'(s2_r[i]));
        chk("s2 done pulses", 32'(done_cnt), 1);

        // Continuous wrap; colour change mid-frame lands on the next frame
        clear_caps();
        mode = 2'd2; color = 3'd0; cont = 1'b1; out_ready = 1'b1;
        pulse_start();
        step(2);
        color = 3'd7; cont = 1'b0;
        step(20);
        chk("s3 beat count", 32'(cap_r.size()), 16);
        for (int i = 0; i < 16 && i < cap_r.size(); i++)
            chk("s3 RGB", 32'(cap_r[i]), 32'(s3_r[i]));
        if (cap_t.size() >= 9 && done_t.size() >= 1) begin
            chk("s3 no gap at wrap", 32'(cap_t[8] - cap_t[7]), 1);
            chk("s3 done with (0,0)", 32'(done_t[0]), 32'(cap_t[8]));
            chk("s3 wrap hpos", 32'(cap_h[8]), 0);
            chk("s3 wrap vpos", 32'(cap_v[8]), 0);
        end else begin
            chk("s3 capture depth", 32'(cap_t.size()), 16);
        end
        chk("s3 done pulses", 32'(done_cnt), 2);

        // Abort during beat 3
        clear_caps();
        mode = 2'd0; color = 3'd5; cont = 1'b0; out_ready = 1'b1;
        pulse_start();
        step(3);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        chk("s4 valid after stop", 32'(out_valid), 0);
        chk("s4 busy after stop", 32'(busy), 0);
        chk("s4 beats before stop", 32'(cap_h.size()), 3);
        step(3);
        chk("s4 no done", 32'(done_cnt), 0);
        clear_caps();
        pulse_start();
        step(12);
        chk("s4 restart beats", 32'(cap_h.size()), 8);
        if (cap_h.size() > 0) begin
            chk("s4 restart hpos", 32'(cap_h[0]), 0);
            chk("s4 restart vpos", 32'(cap_v[0]), 0);
        end

        // Reset mid-frame with sink stalled; start ignored under reset
        clear_caps();
        mode = 2'd3; color = 3'd2; cont = 1'b0; out_ready = 1'b1;
        pulse_start();
        step(4);
        out_ready = 1'b0;
        step(1);
        chk("s5 stalled hpos", 32'(hpos), 0);
        chk("s5 stalled vpos", 32'(vpos), 4);
        rst = 1'b1; start = 1'b1;
        step(1);
        chk("s5 rst valid", 32'(out_valid), 0);
        chk("s5 rst busy", 32'(busy), 0);
        chk("s5 rst hpos", 32'(hpos), 0);
        chk("s5 rst vpos", 32'(vpos), 0);
        chk("s5 rst RGB", 32'(RGB), 0);
        chk("s5 rst done", 32'(frame_done), 0);
        step(1);
        rst = 1'b0; start = 1'b0;
        step(1);
        chk("s5 start ignored", 32'(out_valid), 0);

        // start+stop together in IDLE, then start while busy
        out_ready = 1'b1;
        start = 1'b1; stop = 1'b1;
        step(1);
        start = 1'b0; stop = 1'b0;
        step(1);
        chk("s6 stays idle", 32'(out_valid), 0);
        clear_caps();
        mode = 2'd1; color = 3'b001; cont = 1'b0;
        pulse_start();
        mode = 2'd0; color = 3'd7;
        step(2);
        pulse_start();
        step(12);
        chk("s6 beat count", 32'(cap_r.size()), 8);
        for (int i = 0; i < 8 && i < cap_r.size(); i++)
            chk("s6 RGB", 32'(cap_r[i]), 32'(s2_r[i]));
        chk("s6 done pulses", 32'(done_cnt), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
